// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TX FIFO plus serializer with programmable divisor; reads are combinational.
// Latency: a pushed byte reaches the line as a start bit two clocks later when idle. A push into a full FIFO is dropped and flags overflow.
// Optional feature macro UART_TX_IRQ_EN adds CTRL[0] irq_enable and a registered irq output.
module mmio_uart_tx #(
   parameter int unsigned FIFO_DEPTH  = 8,
   parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sel,
   input  logic [3:0]  addr,
   input  logic        wr_en,
   input  logic [3:0]  wr_mask,
   input  logic [31:0] wr_data,
   output logic [31:0] rd_data,
`ifdef UART_TX_IRQ_EN
   output logic        irq,
`endif
   output logic        tx
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;
   logic [15:0]   div_q, div_d;
   state_t        state_q, state_d;
   logic [15:0]   cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;

   logic wr_acc, push, push_ok, pop, ovf_clr, full, empty, busy;
   logic unused_bits;

   assign wr_acc  = sel & wr_en;
   assign full    = (count_q == DEPTH_C);
   assign empty   = (count_q == '0);
   assign busy    = (state_q != S_IDLE);
   assign push    = wr_acc && (addr == 4'h0) && wr_mask[0];
   assign push_ok = push & ~full;
   assign ovf_clr = wr_acc && (addr == 4'h4) && wr_mask[0] && wr_data[3];
   assign tx      = tx_q;
   assign unused_bits = ^{wr_data[31:16], wr_mask[3:2]};

   // FIFO pointers, occupancy and sticky overflow; overflow set wins over a same-cycle clear
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      if (push_ok) wptr_d = wptr_q + AW'(1);
      if (pop)     rptr_d = rptr_q + AW'(1);
      case ({push_ok, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      if (ovf_clr)      ovf_d = 1'b0;
      if (push && full) ovf_d = 1'b1;
   end

   always_comb begin
      div_d = div_q;
      if (wr_acc && (addr == 4'h8)) begin
         if (wr_mask[0]) div_d[7:0]  = wr_data[7:0];
         if (wr_mask[1]) div_d[15:8] = wr_data[15:8];
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wptr_q] <= wr_data[7:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         div_q   <= DEFAULT_DIV;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         div_q   <= div_d;
      end
   end

   // Serializer: every bit start reloads the timer from the divisor in force at that moment
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      pop     = 1'b0;
      case (state_q)
         S_IDLE: begin
            tx_d = 1'b1;
            if (!empty) begin
               pop     = 1'b1;
               shift_d = mem_q[rptr_q];
               cnt_d   = div_q;
               tx_d    = 1'b0;
               state_d = S_START;
            end
         end
         S_START: begin
            if (cnt_q == 16'd0) begin
               state_d = S_DATA;
               idx_d   = 3'd0;
               cnt_d   = div_q;
               tx_d    = shift_q[0];
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         S_DATA: begin
            if (cnt_q == 16'd0) begin
               cnt_d = div_q;
               if (idx_q == 3'd7) begin
                  state_d = S_STOP;
                  tx_d    = 1'b1;
               end else begin
                  idx_d = idx_q + 3'd1;
                  tx_d  = shift_q[idx_q + 3'd1];
               end
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         S_STOP: begin
            if (cnt_q == 16'd0) begin
               state_d = S_IDLE;
               tx_d    = 1'b1;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
      end
   end

`ifdef UART_TX_IRQ_EN
   logic ctrl_q, ctrl_d, irq_q;

   always_comb begin
      ctrl_d = ctrl_q;
      if (wr_acc && (addr == 4'hC) && wr_mask[0]) ctrl_d = wr_data[0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl_q <= 1'b0;
         irq_q  <= 1'b0;
      end else begin
         ctrl_q <= ctrl_d;
         irq_q  <= ctrl_q & empty & ~busy;
      end
   end

   assign irq = irq_q;
`endif

   always_comb begin
      rd_data = '0;
      if (sel) begin
         case (addr)
            4'h4:    rd_data = {16'h0, 8'(count_q), 4'h0, ovf_q, busy, empty, full};
            4'h8:    rd_data = {16'h0, div_q};
`ifdef UART_TX_IRQ_EN
            4'hC:    rd_data = {31'h0, ctrl_q};
`endif
            default: rd_data = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: randomized frames and register accesses against a waveform-level reference model.
module tb_mmio_uart_tx;
   localparam int          DEPTH   = 8;
   localparam logic [31:0] DEF_DIV = 32'd867;

   logic        clk = 1'b0;
   logic        reset;
   logic        sel, wr_en;
   logic [3:0]  addr, wr_mask;
   logic [31:0] wr_data, rd_data;
   logic        tx;
`ifdef UART_TX_IRQ_EN
   logic        irq;
`endif

   int n_checks = 0;
   int n_pass   = 0;
   logic [7:0] bytes_q [8];

   mmio_uart_tx #(.FIFO_DEPTH(DEPTH), .DEFAULT_DIV(16'd867)) dut (
      .clk     (clk),
      .reset   (reset),
      .sel     (sel),
      .addr    (addr),
      .wr_en   (wr_en),
      .wr_mask (wr_mask),
      .wr_data (wr_data),
      .rd_data (rd_data),
`ifdef UART_TX_IRQ_EN
      .irq     (irq),
`endif
      .tx      (tx)
   );

   always #5 clk = ~clk;

   task automatic idle_bus();
      sel = 1'b0; wr_en = 1'b0; addr = 4'h0; wr_mask = 4'h0; wr_data = 32'h0;
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
      sel = 1'b1; wr_en = 1'b1; addr = a; wr_data = d; wr_mask = m;
      @(negedge clk);
      idle_bus();
   endtask

   task automatic rd(input logic [3:0] a, output logic [31:0] d);
      sel = 1'b1; wr_en = 1'b0; addr = a;
      #1;
      d = rd_data;
      idle_bus();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] v;
      idle_bus();
      do_reset();
      n_checks++; if (tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", tx); else n_pass++;
      rd(4'h4, v);
      n_checks++; if (v !== 32'h2) $display("FAIL reset_status: got %h want 00000002", v); else n_pass++;
      rd(4'h8, v);
      n_checks++; if (v !== DEF_DIV) $display("FAIL reset_div: got %h want %h", v, DEF_DIV); else n_pass++;
      rd(4'h0, v);
      n_checks++; if (v !== 32'h0) $display("FAIL reset_data_rd: got %h want 0", v); else n_pass++;
      rd(4'hC, v);
      n_checks++; if (v !== 32'h0) $display("FAIL reset_ctrl: got %h want 0", v); else n_pass++;
`ifdef UART_TX_IRQ_EN
      n_checks++; if (irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq); else n_pass++;
`endif
   endtask

   task automatic test_regs();
      logic [31:0] v, d, ctrl_exp;
      logic [15:0] div_m;
      logic [3:0]  m;
      do_reset();
      div_m = 16'd867;
      for (int k = 0; k < 5; k++) begin
         d = $urandom;
         m = 4'($urandom_range(0, 15));
         wr(4'h8, d, m);
         if (m[0]) div_m[7:0]  = d[7:0];
         if (m[1]) div_m[15:8] = d[15:8];
         rd(4'h8, v);
         n_checks++; if (v !== {16'h0, div_m}) $display("FAIL div_lane[%0d]: got %h want %h", k, v, {16'h0, div_m}); else n_pass++;
      end
      sel = 1'b0; wr_en = 1'b1; addr = 4'h8; wr_data = 32'h0000_1111; wr_mask = 4'hF;
      @(negedge clk);
      idle_bus();
      wr(4'h9, 32'h0000_2222, 4'hF);
      rd(4'h8, v);
      n_checks++; if (v !== {16'h0, div_m}) $display("FAIL div_ignored: got %h want %h", v, {16'h0, div_m}); else n_pass++;
      sel = 1'b0; wr_en = 1'b1; addr = 4'h0; wr_data = 32'h5A; wr_mask = 4'h1;
      @(negedge clk);
      idle_bus();
      wr(4'h4, 32'hFFFF_FFFF, 4'hF);
      wr(4'h0, 32'h0000_00C3, 4'hE);
      rd(4'h4, v);
      n_checks++; if (v !== 32'h2) $display("FAIL status_ro: got %h want 00000002", v); else n_pass++;
      wr(4'hC, 32'h1, 4'h1);
`ifdef UART_TX_IRQ_EN
      ctrl_exp = 32'h1;
`else
      ctrl_exp = 32'h0;
`endif
      rd(4'hC, v);
      n_checks++; if (v !== ctrl_exp) $display("FAIL ctrl_rw: got %h want %h", v, ctrl_exp); else n_pass++;
      wr(4'hC, 32'h0, 4'h1);
   endtask

   task automatic test_basic_frame();
      logic [31:0] v;
      logic [7:0]  b;
      logic        e;
      int          bi;
      b = 8'h55;
      do_reset();
      wr(4'h8, 32'd3, 4'b0011);
      wr(4'h0, {24'h0, b}, 4'b0001);
      for (int i = 0; i < 45; i++) begin
         if (i == 0 || i > 40) e = 1'b1;
         else begin
            bi = (i - 1) / 4;
            e = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : b[bi-1];
         end
         n_checks++; if (tx !== e) $display("FAIL frame55_tx[%0d]: got %b want %b", i, tx, e); else n_pass++;
         if (i == 40 || i == 41) begin
            rd(4'h4, v);
            n_checks++; if (v[2] !== (i == 40)) $display("FAIL frame55_busy[%0d]: got %b want %b", i, v[2], (i == 40)); else n_pass++;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_stream(input int div, input int n);
      bit          exp[$];
      logic [31:0] v;
      do_reset();
      wr(4'h8, div, 4'b0011);
      for (int k = 0; k < n; k++) begin
         exp.push_back(1'b1);
         for (int b = 0; b < 10; b++) begin
            bit bv;
            bv = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : bytes_q[k][b-1];
            repeat (div + 1) exp.push_back(bv);
         end
      end
      repeat (4) exp.push_back(1'b1);
      for (int k = 0; k < n; k++) wr(4'h0, {24'h0, bytes_q[k]}, 4'b0001);
      repeat (n - 1) void'(exp.pop_front());
      for (int i = 0; i < exp.size(); i++) begin
         n_checks++; if (tx !== exp[i]) $display("FAIL stream_tx div=%0d n=%0d cyc=%0d: got %b want %b", div, n, i, tx, exp[i]); else n_pass++;
         @(negedge clk);
      end
      rd(4'h4, v);
      n_checks++; if (v !== 32'h2) $display("FAIL stream_status div=%0d: got %h want 00000002", div, v); else n_pass++;
   endtask

   task automatic test_back_to_back();
      bytes_q[0] = 8'hA0; bytes_q[1] = 8'h0F;
      test_stream(0, 2);
      for (int r = 0; r < 4; r++) begin
         int n;
         n = $urandom_range(1, 4);
         for (int k = 0; k < n; k++) bytes_q[k] = 8'($urandom);
         test_stream($urandom_range(0, 3), n);
      end
   endtask

   task automatic test_overflow();
      logic [31:0] v, e;
      int          queued;
      do_reset();
      wr(4'h8, 32'h0000_FFFF, 4'b0011);
      for (int k = 1; k <= 10; k++) begin
         wr(4'h0, k, 4'b0001);
         if (k >= 9) begin
            queued = (k - 1 > DEPTH) ? DEPTH : k - 1;
            e = (queued << 8) | (((k - 1) > DEPTH) ? 32'h8 : 32'h0) | 32'h4 | ((queued == DEPTH) ? 32'h1 : 32'h0);
            rd(4'h4, v);
            n_checks++; if (v !== e) $display("FAIL ovf_status_after_%0d: got %h want %h", k, v, e); else n_pass++;
         end
      end
      wr(4'h4, 32'h8, 4'b0000);
      rd(4'h4, v);
      n_checks++; if (v !== 32'h80D) $display("FAIL ovf_masked_w1c: got %h want 0000080d", v); else n_pass++;
      wr(4'h4, 32'h7, 4'b0001);
      rd(4'h4, v);
      n_checks++; if (v !== 32'h80D) $display("FAIL ovf_w1c_zero: got %h want 0000080d", v); else n_pass++;
      wr(4'h4, 32'h8, 4'b0001);
      rd(4'h4, v);
      n_checks++; if (v !== 32'h805) $display("FAIL ovf_w1c: got %h want 00000805", v); else n_pass++;
   endtask

   task automatic test_div_change();
      bit         exp[$];
      logic [7:0] b;
      b = 8'($urandom);
      do_reset();
      wr(4'h8, 32'd7, 4'b0011);
      exp.push_back(1'b1);
      repeat (8) exp.push_back(1'b0);
      for (int k = 0; k < 8; k++) repeat (2) exp.push_back(b[k]);
      repeat (2) exp.push_back(1'b1);
      repeat (3) exp.push_back(1'b1);
      wr(4'h0, {24'h0, b}, 4'b0001);
      for (int i = 0; i < exp.size(); i++) begin
         n_checks++; if (tx !== exp[i]) $display("FAIL divchg_tx[%0d]: got %b want %b", i, tx, exp[i]); else n_pass++;
         if (i == 3) begin
            sel = 1'b1; wr_en = 1'b1; addr = 4'h8; wr_data = 32'd1; wr_mask = 4'b0011;
         end else if (i == 4) begin
            idle_bus();
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset_midframe();
      logic [31:0] v;
      int          lows;
      for (int k = 0; k < 4; k++) bytes_q[k] = 8'($urandom);
      do_reset();
      wr(4'h8, 32'd3, 4'b0011);
      for (int k = 0; k < 4; k++) wr(4'h0, {24'h0, bytes_q[k]}, 4'b0001);
      repeat (19) @(negedge clk);
      n_checks++; if (tx !== bytes_q[0][4]) $display("FAIL mid_bit4: got %b want %b", tx, bytes_q[0][4]); else n_pass++;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      n_checks++; if (tx !== 1'b1) $display("FAIL mid_tx_after_reset: got %b want 1", tx); else n_pass++;
      rd(4'h4, v);
      n_checks++; if (v !== 32'h2) $display("FAIL mid_status: got %h want 00000002", v); else n_pass++;
      rd(4'h8, v);
      n_checks++; if (v !== DEF_DIV) $display("FAIL mid_div: got %h want %h", v, DEF_DIV); else n_pass++;
      lows = 0;
      repeat (200) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
      n_checks++; if (lows !== 0) $display("FAIL mid_no_frames: got %0d low cycles want 0", lows); else n_pass++;
   endtask

`ifdef UART_TX_IRQ_EN
   task automatic test_irq();
      logic [31:0] v;
      do_reset();
      wr(4'hC, 32'h1, 4'b0001);
      wr(4'h8, 32'd3, 4'b0011);
      n_checks++; if (irq !== 1'b1) $display("FAIL irq_idle: got %b want 1", irq); else n_pass++;
      wr(4'h0, 32'h3C, 4'b0001);
      for (int i = 0; i <= 42; i++) begin
         if (i >= 1) begin
            n_checks++; if (irq !== (i >= 42)) $display("FAIL irq_frame[%0d]: got %b want %b", i, irq, (i >= 42)); else n_pass++;
         end
         @(negedge clk);
      end
      rd(4'hC, v);
      n_checks++; if (v !== 32'h1) $display("FAIL irq_ctrl_rd: got %h want 1", v); else n_pass++;
      wr(4'hC, 32'h0, 4'b0001);
      @(negedge clk);
      n_checks++; if (irq !== 1'b0) $display("FAIL irq_disable: got %b want 0", irq); else n_pass++;
   endtask
`endif

   initial begin
      reset = 1'b1;
      idle_bus();
      test_reset();
      test_regs();
      test_basic_frame();
      test_back_to_back();
      test_overflow();
      test_div_change();
      test_reset_midframe();
`ifdef UART_TX_IRQ_EN
      test_irq();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
